// File: rtl/fpga_exec_pkg.sv
// ---------------------------------------------------------------------------
// fpga_exec_pkg
// Shared definitions for the fpga_exec instruction executor: the 3-bit opcode
// constants, the controller state encoding and a small decode helper.
// ---------------------------------------------------------------------------
package fpga_exec_pkg;

    localparam logic [2:0] OP_HALT = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_MOVI = 3'd3;
    localparam logic [2:0] OP_OUT  = 3'd4;
    localparam logic [2:0] OP_JZ   = 3'd5;
    localparam logic [2:0] OP_JNZ  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Opcodes whose result is written back into local memory.
    function automatic logic isAluWrite(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MOVI);
    endfunction

endpackage

// File: rtl/fpga_exec_alu.sv
// ---------------------------------------------------------------------------
// fpga_exec_alu
// Purely combinational datapath for fpga_exec.
// Ports:
//   i_op     opcode of the current instruction
//   i_a/i_b  local memory operands selected by fields a and b
//   i_imm    raw b field, used as the MOVI immediate
//   o_result value to write to local[d]
//   o_write  high when the opcode writes local memory
//   o_aZero  high when operand a is zero (branch condition)
// ---------------------------------------------------------------------------
module fpga_exec_alu
    import fpga_exec_pkg::*;
#(
    parameter int MemoryElementWidth = 12,
    parameter int FieldWidth         = 8
)(
    input  logic [2:0]                    i_op,
    input  logic [MemoryElementWidth-1:0] i_a,
    input  logic [MemoryElementWidth-1:0] i_b,
    input  logic [FieldWidth-1:0]         i_imm,
    output logic [MemoryElementWidth-1:0] o_result,
    output logic                          o_write,
    output logic                          o_aZero
);

    // Arithmetic wraps naturally at the word width; the immediate is
    // zero-extended or truncated to the word width by the size cast.
    always_comb begin
        o_result = '0;
        case (i_op)
            OP_ADD:  o_result = i_a + i_b;
            OP_SUB:  o_result = i_a - i_b;
            OP_MOVI: o_result = MemoryElementWidth'(i_imm);
            default: o_result = '0;
        endcase
    end

    assign o_write = isAluWrite(i_op);
    assign o_aZero = (i_a == '0);

endmodule

// File: rtl/fpga_exec.sv
// ---------------------------------------------------------------------------
// fpga_exec
// Small program executor: loads a program and a table of expected outputs
// while idle, then runs one instruction per clock, checking every OUT value
// against the expected table and reporting pass/fail/timeout at the end.
// Ports:
//   clock, reset                      clock and synchronous active-high reset
//   codeWe/codeAddr/codeData          instruction memory write port
//   expWe/expAddr/expData             expected-output memory write port
//   expCount                          number of outputs to check (at start)
//   start                             one-cycle pulse, begins at ip 0
//   outValid/outData                  one-cycle strobe per OUT
//   steps                             instructions executed since start
//   finished/success/timedOut         completion status
// ---------------------------------------------------------------------------
module fpga_exec
    import fpga_exec_pkg::*;
#(
    parameter int MemoryElementWidth = 12,
    parameter int NLocal             = 16,
    parameter int NOut               = 8,
    parameter int NCode              = 32,
    parameter int FieldWidth         = 8,
    parameter int MaxSteps           = 1000,
    localparam int IW  = 3 + 3 * FieldWidth,
    localparam int CAW = (NCode > 1) ? $clog2(NCode) : 1,
    localparam int OAW = (NOut > 1) ? $clog2(NOut) : 1,
    localparam int LW  = (NLocal > 1) ? $clog2(NLocal) : 1
)(
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          codeWe,
    input  logic [CAW-1:0]                codeAddr,
    input  logic [IW-1:0]                 codeData,
    input  logic                          expWe,
    input  logic [OAW-1:0]                expAddr,
    input  logic [MemoryElementWidth-1:0] expData,
    input  logic [OAW:0]                  expCount,
    input  logic                          start,
    output logic                          outValid,
    output logic [MemoryElementWidth-1:0] outData,
    output logic [31:0]                   steps,
    output logic                          finished,
    output logic                          success,
    output logic                          timedOut
);

    // The ip must hold any jump target (a full d field) and also NCode
    // itself, so that running off the end of the program is detectable.
    localparam int IPW = (FieldWidth > CAW + 1) ? FieldWidth : CAW + 1;
    localparam logic [IPW-1:0] CODE_LIMIT = IPW'(NCode);
    localparam logic [OAW:0]   OUT_LIMIT  = (OAW + 1)'(NOut);
    localparam logic [31:0]    STEP_LIMIT = 32'(MaxSteps);

    logic [IW-1:0]                 r_code  [NCode];
    logic [MemoryElementWidth-1:0] r_exp   [NOut];
    logic [MemoryElementWidth-1:0] r_local [NLocal];

    state_t                        r_state;
    logic [IPW-1:0]                r_ip;
    logic [31:0]                   r_steps;
    logic [OAW:0]                  r_outPos;
    logic [OAW:0]                  r_expCount;
    logic                          r_mismatch;
    logic                          r_finished;
    logic                          r_success;
    logic                          r_timedOut;
    logic                          r_outValid;
    logic [MemoryElementWidth-1:0] r_outData;

    logic [IW-1:0]                 w_instr;
    logic [2:0]                    w_op;
    logic [FieldWidth-1:0]         w_fd;
    logic [FieldWidth-1:0]         w_fa;
    logic [FieldWidth-1:0]         w_fb;
    logic [MemoryElementWidth-1:0] w_valA;
    logic [MemoryElementWidth-1:0] w_valB;
    logic [MemoryElementWidth-1:0] w_aluResult;
    logic                          w_aluWrite;
    logic                          w_aZero;
    logic                          w_timeout;
    logic                          w_exec;
    logic                          w_launch;
    logic                          w_unused;

    // An ip past the end of code fetches all-zero, which decodes as HALT.
    assign w_instr = (r_ip < CODE_LIMIT) ? r_code[r_ip[CAW-1:0]] : '0;
    assign w_op    = w_instr[IW-1 -: 3];
    assign w_fd    = w_instr[3*FieldWidth-1 -: FieldWidth];
    assign w_fa    = w_instr[2*FieldWidth-1 -: FieldWidth];
    assign w_fb    = w_instr[FieldWidth-1:0];
    assign w_valA  = r_local[w_fa[LW-1:0]];
    assign w_valB  = r_local[w_fb[LW-1:0]];
    assign w_unused = ^w_fa;

    assign w_timeout = (r_steps == STEP_LIMIT);
    assign w_exec    = (r_state == ST_RUN) && !w_timeout;
    assign w_launch  = (r_state != ST_RUN) && start;

    fpga_exec_alu #(
        .MemoryElementWidth(MemoryElementWidth),
        .FieldWidth        (FieldWidth)
    ) u_alu (
        .i_op    (w_op),
        .i_a     (w_valA),
        .i_b     (w_valB),
        .i_imm   (w_fb),
        .o_result(w_aluResult),
        .o_write (w_aluWrite),
        .o_aZero (w_aZero)
    );

    // Program and expected-output memories: loadable only while not running,
    // and deliberately untouched by reset so a program survives an abort.
    always_ff @(posedge clock) begin
        if (codeWe && (r_state != ST_RUN)) begin
            r_code[codeAddr] <= codeData;
        end
        if (expWe && (r_state != ST_RUN)) begin
            r_exp[expAddr] <= expData;
        end
    end

    // Local register file: cleared on launch, written by ALU ops. Reads are
    // combinational, so the next instruction sees the value just written.
    always_ff @(posedge clock) begin
        if (!reset && w_launch) begin
            for (int i = 0; i < NLocal; i++) begin
                r_local[i] <= '0;
            end
        end else if (!reset && w_exec && w_aluWrite) begin
            r_local[w_fd[LW-1:0]] <= w_aluResult;
        end
    end

    // Controller: launch, one instruction per RUN cycle, and the completion
    // verdict latched on entry to DONE. The step limit is checked before
    // execution so steps never exceeds MaxSteps.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ip       <= '0;
            r_steps    <= '0;
            r_outPos   <= '0;
            r_expCount <= '0;
            r_mismatch <= 1'b0;
            r_finished <= 1'b0;
            r_success  <= 1'b0;
            r_timedOut <= 1'b0;
            r_outValid <= 1'b0;
            r_outData  <= '0;
        end else begin
            r_outValid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_RUN;
                        r_ip       <= '0;
                        r_steps    <= '0;
                        r_outPos   <= '0;
                        r_expCount <= expCount;
                        r_mismatch <= 1'b0;
                        r_finished <= 1'b0;
                        r_success  <= 1'b0;
                        r_timedOut <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_timeout) begin
                        r_state    <= ST_DONE;
                        r_finished <= 1'b1;
                        r_success  <= 1'b0;
                        r_timedOut <= 1'b1;
                    end else begin
                        r_steps <= r_steps + 32'd1;
                        r_ip    <= r_ip + 1'b1;
                        case (w_op)
                            OP_ADD, OP_SUB, OP_MOVI: begin
                            end
                            OP_OUT: begin
                                r_outValid <= 1'b1;
                                r_outData  <= w_valA;
                                if ((r_outPos < r_expCount) && (r_outPos < OUT_LIMIT)) begin
                                    if (w_valA != r_exp[r_outPos[OAW-1:0]]) begin
                                        r_mismatch <= 1'b1;
                                    end
                                end else begin
                                    r_mismatch <= 1'b1;
                                end
                                if (r_outPos < OUT_LIMIT) begin
                                    r_outPos <= r_outPos + 1'b1;
                                end
                            end
                            OP_JZ: begin
                                if (w_aZero) begin
                                    r_ip <= IPW'(w_fd);
                                end
                            end
                            OP_JNZ: begin
                                if (!w_aZero) begin
                                    r_ip <= IPW'(w_fd);
                                end
                            end
                            default: begin
                                r_state    <= ST_DONE;
                                r_finished <= 1'b1;
                                r_success  <= !r_mismatch && (r_outPos == r_expCount);
                            end
                        endcase
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign outValid = r_outValid;
    assign outData  = r_outData;
    assign steps    = r_steps;
    assign finished = r_finished;
    assign success  = r_success;
    assign timedOut = r_timedOut;

endmodule

// File: tb/tb_fpga_exec.sv
// ---------------------------------------------------------------------------
// tb_fpga_exec
// Directed bench for fpga_exec. Instance A uses default parameters; instance
// B uses 4-bit words and a 10-step limit for the wrap and timeout cases.
// Expected OUT values are queued when a run is launched and a monitor pops
// and compares them on every strobe.
// ---------------------------------------------------------------------------
module tb_fpga_exec;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    // Instance A signals (default parameters)
    logic        codeWeA = 0, expWeA = 0, startA = 0;
    logic [4:0]  codeAddrA = '0;
    logic [26:0] codeDataA = '0;
    logic [2:0]  expAddrA = '0;
    logic [11:0] expDataA = '0;
    logic [3:0]  expCountA = '0;
    logic        outValidA, finishedA, successA, timedOutA;
    logic [11:0] outDataA;
    logic [31:0] stepsA;

    // Instance B signals (4-bit words, MaxSteps 10)
    logic        codeWeB = 0, expWeB = 0, startB = 0;
    logic [4:0]  codeAddrB = '0;
    logic [26:0] codeDataB = '0;
    logic [2:0]  expAddrB = '0;
    logic [3:0]  expDataB = '0;
    logic [3:0]  expCountB = '0;
    logic        outValidB, finishedB, successB, timedOutB;
    logic [3:0]  outDataB;
    logic [31:0] stepsB;

    int compareCount = 0;
    int failCount    = 0;
    int qA[$];
    int qB[$];

    fpga_exec dutA (
        .clock(clock), .reset(reset),
        .codeWe(codeWeA), .codeAddr(codeAddrA), .codeData(codeDataA),
        .expWe(expWeA), .expAddr(expAddrA), .expData(expDataA),
        .expCount(expCountA), .start(startA),
        .outValid(outValidA), .outData(outDataA), .steps(stepsA),
        .finished(finishedA), .success(successA), .timedOut(timedOutA)
    );

    fpga_exec #(.MemoryElementWidth(4), .MaxSteps(10)) dutB (
        .clock(clock), .reset(reset),
        .codeWe(codeWeB), .codeAddr(codeAddrB), .codeData(codeDataB),
        .expWe(expWeB), .expAddr(expAddrB), .expData(expDataB),
        .expCount(expCountB), .start(startB),
        .outValid(outValidB), .outData(outDataB), .steps(stepsB),
        .finished(finishedB), .success(successB), .timedOut(timedOutB)
    );

    function automatic logic [26:0] enc(input int op, input int d, input int a, input int b);
        return {op[2:0], d[7:0], a[7:0], b[7:0]};
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compareCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest queued value.
    always @(negedge clock) begin
        if (outValidA) begin
            if (qA.size() == 0) begin
                compareCount++;
                failCount++;
                $display("[TB] FAIL outA_extra: got strobe %0d, expected none", outDataA);
            end else begin
                checkOutput("outA", int'(outDataA), qA.pop_front());
            end
        end
        if (outValidB) begin
            if (qB.size() == 0) begin
                compareCount++;
                failCount++;
                $display("[TB] FAIL outB_extra: got strobe %0d, expected none", outDataB);
            end else begin
                checkOutput("outB", int'(outDataB), qB.pop_front());
            end
        end
    end

    task automatic applyStimulus(input bit onB, input bit isExp, input int addr, input logic [26:0] data);
        if (!onB && !isExp) begin codeWeA = 1; codeAddrA = addr[4:0]; codeDataA = data; end
        if (!onB &&  isExp) begin expWeA  = 1; expAddrA  = addr[2:0]; expDataA  = data[11:0]; end
        if ( onB && !isExp) begin codeWeB = 1; codeAddrB = addr[4:0]; codeDataB = data; end
        if ( onB &&  isExp) begin expWeB  = 1; expAddrB  = addr[2:0]; expDataB  = data[3:0]; end
        @(negedge clock);
        codeWeA = 0; expWeA = 0; codeWeB = 0; expWeB = 0;
    endtask

    task automatic launchA(input int cnt);
        expCountA = cnt[3:0];
        startA = 1;
        @(negedge clock);
        startA = 0;
    endtask

    task automatic launchB(input int cnt);
        expCountB = cnt[3:0];
        startB = 1;
        @(negedge clock);
        startB = 0;
    endtask

    task automatic waitA(input string name);
        int n = 0;
        while (!finishedA && n < 300) begin @(negedge clock); n++; end
        checkOutput({name, "_finished"}, int'(finishedA), 1);
    endtask

    task automatic waitB(input string name);
        int n = 0;
        while (!finishedB && n < 300) begin @(negedge clock); n++; end
        checkOutput({name, "_finished"}, int'(finishedB), 1);
    endtask

    task automatic checkResetA(input string name);
        checkOutput({name, "_outValid"}, int'(outValidA), 0);
        checkOutput({name, "_outData"},  int'(outDataA), 0);
        checkOutput({name, "_steps"},    int'(stepsA), 0);
        checkOutput({name, "_finished"}, int'(finishedA), 0);
        checkOutput({name, "_success"},  int'(successA), 0);
        checkOutput({name, "_timedOut"}, int'(timedOutA), 0);
    endtask

    task automatic loadLoopA();
        applyStimulus(0, 0, 0, enc(3, 0, 0, 4));
        applyStimulus(0, 0, 1, enc(3, 1, 0, 1));
        applyStimulus(0, 0, 2, enc(4, 0, 0, 0));
        applyStimulus(0, 0, 3, enc(2, 0, 0, 1));
        applyStimulus(0, 0, 4, enc(6, 2, 0, 0));
        applyStimulus(0, 0, 5, enc(0, 0, 0, 0));
        for (int i = 0; i < 4; i++) applyStimulus(0, 1, i, 27'(4 - i));
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clock);
        checkResetA("resetA");
        checkOutput("resetB_finished", int'(finishedB), 0);
        reset = 0;
        @(negedge clock);

        // Straight-line add: 3 + 2 = 5
        applyStimulus(0, 0, 0, enc(3, 0, 0, 3));
        applyStimulus(0, 0, 1, enc(3, 1, 0, 2));
        applyStimulus(0, 0, 2, enc(1, 2, 0, 1));
        applyStimulus(0, 0, 3, enc(4, 0, 2, 0));
        applyStimulus(0, 0, 4, enc(0, 0, 0, 0));
        applyStimulus(0, 1, 0, 27'd5);
        qA.push_back(5);
        launchA(1);
        waitA("add");
        checkOutput("add_success",  int'(successA), 1);
        checkOutput("add_steps",    int'(stepsA), 5);
        checkOutput("add_timedOut", int'(timedOutA), 0);
        repeat (3) @(negedge clock);
        checkOutput("add_heldFinished", int'(finishedA), 1);
        checkOutput("add_heldData",     int'(outDataA), 5);

        // Same program, wrong expected value
        applyStimulus(0, 1, 0, 27'd6);
        qA.push_back(5);
        launchA(1);
        waitA("bad");
        checkOutput("bad_success",  int'(successA), 0);
        checkOutput("bad_timedOut", int'(timedOutA), 0);

        // OUT with nothing left to check must fail the run
        qA.push_back(5);
        launchA(0);
        waitA("extra");
        checkOutput("extra_success", int'(successA), 0);

        // Countdown loop 4,3,2,1
        loadLoopA();
        for (int i = 4; i >= 1; i--) qA.push_back(i);
        launchA(4);
        waitA("loop");
        checkOutput("loop_success", int'(successA), 1);
        checkOutput("loop_steps",   int'(stepsA), 15);

        // Abort mid-run after three steps, then rerun to success
        qA.push_back(4);
        launchA(4);
        n = 0;
        while (stepsA != 3 && n < 50) begin @(negedge clock); n++; end
        checkOutput("abort_reachedStep3", int'(stepsA), 3);
        reset = 1;
        @(negedge clock);
        checkResetA("abort");
        reset = 0;
        @(negedge clock);
        for (int i = 4; i >= 1; i--) qA.push_back(i);
        launchA(4);
        waitA("rerun");
        checkOutput("rerun_success", int'(successA), 1);
        checkOutput("rerun_steps",   int'(stepsA), 15);

        // Infinite JZ loop on B; a code write during RUN must be ignored
        applyStimulus(1, 0, 0, enc(5, 0, 0, 0));
        launchB(0);
        applyStimulus(1, 0, 0, enc(0, 0, 0, 0));
        waitB("timeout");
        checkOutput("timeout_steps",    int'(stepsB), 10);
        checkOutput("timeout_timedOut", int'(timedOutB), 1);
        checkOutput("timeout_success",  int'(successB), 0);

        // 4-bit wrap: MOVI 255 -> 15, 15 + 15 = 14 mod 16
        applyStimulus(1, 0, 0, enc(3, 0, 0, 255));
        applyStimulus(1, 0, 1, enc(1, 0, 0, 0));
        applyStimulus(1, 0, 2, enc(4, 0, 0, 0));
        applyStimulus(1, 0, 3, enc(0, 0, 0, 0));
        applyStimulus(1, 1, 0, 27'd14);
        qB.push_back(14);
        launchB(1);
        waitB("wrap");
        checkOutput("wrap_success",  int'(successB), 1);
        checkOutput("wrap_steps",    int'(stepsB), 4);
        checkOutput("wrap_timedOut", int'(timedOutB), 0);

        repeat (4) @(negedge clock);
        checkOutput("pendingA", qA.size(), 0);
        checkOutput("pendingB", qB.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
